// File: rtl/branch_predict_ctrl_if.sv
// Fetch-lookup, EX-resolve and redirect bundle between the
// pipeline and the branch predictor.
interface branch_predict_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic [PC_W-1:0]  pc_f;
  logic             pred_taken_f;
  logic [PC_W-1:0]  pred_target_f;
  logic             ex_valid;
  logic [1:0]       ex_jtype;
  logic [PC_W-1:0]  ex_pc;
  logic             ex_taken;
  logic [PC_W-1:0]  ex_target;
  logic             ex_pred_taken;
  logic [PC_W-1:0]  ex_pred_target;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_mispredicts;

  modport master (
    output pc_f,
    output ex_valid,
    output ex_jtype,
    output ex_pc,
    output ex_taken,
    output ex_target,
    output ex_pred_taken,
    output ex_pred_target,
    input  pred_taken_f,
    input  pred_target_f,
    input  redirect,
    input  redirect_pc,
    input  stat_branches,
    input  stat_mispredicts
  );

  modport slave (
    input  pc_f,
    input  ex_valid,
    input  ex_jtype,
    input  ex_pc,
    input  ex_taken,
    input  ex_target,
    input  ex_pred_taken,
    input  ex_pred_target,
    output pred_taken_f,
    output pred_target_f,
    output redirect,
    output redirect_pc,
    output stat_branches,
    output stat_mispredicts
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// Direct-mapped BHT/BTB predictor with EX-stage mispredict
// detection, PC redirect, table training and saturating stats.
module branch_predict_ctrl #(
  parameter int IDX_W = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  branch_predict_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic [1:0]       bht_q     [DEPTH];
  logic [1:0]       bht_d     [DEPTH];
  logic [DEPTH-1:0] btb_v_q;
  logic [DEPTH-1:0] btb_v_d;
  logic [TAG_W-1:0] btb_tag_q [DEPTH];
  logic [TAG_W-1:0] btb_tag_d [DEPTH];
  logic [PC_W-1:0]  btb_tgt_q [DEPTH];
  logic [PC_W-1:0]  btb_tgt_d [DEPTH];
  logic [CNT_W-1:0] st_br_q;
  logic [CNT_W-1:0] st_br_d;
  logic [CNT_W-1:0] st_mp_q;
  logic [CNT_W-1:0] st_mp_d;

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic [IDX_W-1:0] e_idx;
  logic [TAG_W-1:0] e_tag;
  logic             res;
  logic             is_cond;
  logic             is_jump;
  logic             dir_miss;
  logic             tgt_miss;
  logic             mispredict;
  logic             unused_pc_lsb;

  assign unused_pc_lsb = ^{bus.pc_f[1:0], bus.ex_pc[1:0]};

  assign f_idx = bus.pc_f[IDX_W+1:2];
  assign f_tag = bus.pc_f[PC_W-1:IDX_W+2];
  assign f_hit = btb_v_q[f_idx] & (btb_tag_q[f_idx] == f_tag);

  assign bus.pred_taken_f  = rst & f_hit & bht_q[f_idx][1];
  assign bus.pred_target_f = f_hit ? btb_tgt_q[f_idx] : '0;

  assign e_idx   = bus.ex_pc[IDX_W+1:2];
  assign e_tag   = bus.ex_pc[PC_W-1:IDX_W+2];
  assign res     = rst & bus.ex_valid & (bus.ex_jtype != 2'b00);
  assign is_cond = bus.ex_jtype == 2'b11;
  assign is_jump = (bus.ex_jtype == 2'b01) | (bus.ex_jtype == 2'b10);

  assign dir_miss = bus.ex_taken != bus.ex_pred_taken;
  assign tgt_miss = bus.ex_taken & bus.ex_pred_taken &
                    (bus.ex_target != bus.ex_pred_target);
  assign mispredict = res & (dir_miss | tgt_miss);

  // Fall-through PC whenever no taken redirect is in flight
  assign bus.redirect    = mispredict;
  assign bus.redirect_pc = (mispredict & bus.ex_taken) ?
                           bus.ex_target :
                           bus.ex_pc + PC_W'(4);

  assign bus.stat_branches    = st_br_q;
  assign bus.stat_mispredicts = st_mp_q;

  always_comb begin
    bht_d     = bht_q;
    btb_v_d   = btb_v_q;
    btb_tag_d = btb_tag_q;
    btb_tgt_d = btb_tgt_q;
    if (res) begin
      unique case (1'b1)
        is_cond: begin
          if (bus.ex_taken) begin
            if (bht_q[e_idx] != 2'b11)
              bht_d[e_idx] = bht_q[e_idx] + 2'b01;
          end else begin
            if (bht_q[e_idx] != 2'b00)
              bht_d[e_idx] = bht_q[e_idx] - 2'b01;
          end
        end
        is_jump: bht_d[e_idx] = 2'b11;
        default: ;
      endcase
      if (bus.ex_taken) begin
        btb_v_d[e_idx]   = 1'b1;
        btb_tag_d[e_idx] = e_tag;
        btb_tgt_d[e_idx] = bus.ex_target;
      end
    end
  end

  always_comb begin
    st_br_d = st_br_q;
    st_mp_d = st_mp_q;
    if (res && (st_br_q != '1))
      st_br_d = st_br_q + CNT_W'(1);
    if (mispredict && (st_mp_q != '1))
      st_mp_d = st_mp_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        bht_q[k]     <= 2'b01;
        btb_tag_q[k] <= '0;
        btb_tgt_q[k] <= '0;
      end
      btb_v_q <= '0;
      st_br_q <= '0;
      st_mp_q <= '0;
    end else begin
      bht_q     <= bht_d;
      btb_v_q   <= btb_v_d;
      btb_tag_q <= btb_tag_d;
      btb_tgt_q <= btb_tgt_d;
      st_br_q   <= st_br_d;
      st_mp_q   <= st_mp_d;
    end
  end
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl: lookup, redirect,
// training, aliasing, stat saturation and async reset.
module tb_branch_predict_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  branch_predict_ctrl_if #(.PC_W(32), .CNT_W(16)) bus ();

  branch_predict_ctrl #(
    .IDX_W(4),
    .PC_W(32),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    if (o !== e) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [1:0] jt,
                        input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt, input logic ptk,
                        input logic [31:0] ptgt);
    bus.ex_valid       = v;
    bus.ex_jtype       = jt;
    bus.ex_pc          = pc;
    bus.ex_taken       = tk;
    bus.ex_target      = tgt;
    bus.ex_pred_taken  = ptk;
    bus.ex_pred_target = ptgt;
  endtask

  task automatic idle();
    set_ex(1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    idle();
    bus.pc_f = 32'h40;
    #1 rst = 1'b0;
    set_ex(1'b1, 2'b11, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    chk("rst_pred", bus.pred_taken_f, 1'b0);
    chk("rst_redir", bus.redirect, 1'b0);
    chk("rst_br", bus.stat_branches, 16'h0);
    chk("rst_mp", bus.stat_mispredicts, 16'h0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("s2_redir", bus.redirect, 1'b1);
    chk("s2_rpc", bus.redirect_pc, 32'h80);
    chk("s2_pred_pre", bus.pred_taken_f, 1'b0);
    tick();
    idle();
    #1;
    chk("s2_pred", bus.pred_taken_f, 1'b1);
    chk("s2_tgt", bus.pred_target_f, 32'h80);
    chk("s2_br", bus.stat_branches, 16'd1);
    chk("s2_mp", bus.stat_mispredicts, 16'd1);
    chk("s2_idle_redir", bus.redirect, 1'b0);
    set_ex(1'b1, 2'b11, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80);
    #1;
    chk("s3a_redir", bus.redirect, 1'b1);
    chk("s3a_rpc", bus.redirect_pc, 32'h44);
    tick();
    set_ex(1'b1, 2'b11, 32'h40, 1'b0, 32'h80, 1'b0, 32'h80);
    #1;
    chk("s3b_pred", bus.pred_taken_f, 1'b0);
    chk("s3b_redir", bus.redirect, 1'b0);
    chk("s3b_rpc", bus.redirect_pc, 32'h44);
    tick();
    #1;
    chk("s3c_pred", bus.pred_taken_f, 1'b0);
    chk("s3c_redir", bus.redirect, 1'b0);
    tick();
    idle();
    #1;
    chk("s3_pred", bus.pred_taken_f, 1'b0);
    chk("s3_br", bus.stat_branches, 16'd4);
    chk("s3_mp", bus.stat_mispredicts, 16'd2);
    set_ex(1'b1, 2'b11, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    #1;
    chk("s3d_redir", bus.redirect, 1'b1);
    tick();
    idle();
    #1;
    chk("s3_sat_pred", bus.pred_taken_f, 1'b0);
    bus.pc_f = 32'h100;
    set_ex(1'b1, 2'b10, 32'h100, 1'b1, 32'h204, 1'b1, 32'h200);
    #1;
    chk("s4_redir", bus.redirect, 1'b1);
    chk("s4_rpc", bus.redirect_pc, 32'h204);
    chk("s4_pred_pre", bus.pred_taken_f, 1'b0);
    tick();
    idle();
    #1;
    chk("s4_pred", bus.pred_taken_f, 1'b1);
    chk("s4_tgt", bus.pred_target_f, 32'h204);
    chk("s4_br", bus.stat_branches, 16'd6);
    chk("s4_mp", bus.stat_mispredicts, 16'd4);
    bus.pc_f = 32'h40;
    #1;
    chk("s4_alias_pred", bus.pred_taken_f, 1'b0);
    chk("s4_alias_tgt", bus.pred_target_f, 32'h0);
    set_ex(1'b1, 2'b01, 32'h100, 1'b1, 32'h204, 1'b1, 32'h204);
    #1;
    chk("jal_redir", bus.redirect, 1'b0);
    chk("jal_rpc", bus.redirect_pc, 32'h104);
    tick();
    idle();
    #1;
    chk("jal_br", bus.stat_branches, 16'd7);
    chk("jal_mp", bus.stat_mispredicts, 16'd4);
    set_ex(1'b1, 2'b11, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    tick();
    idle();
    #1;
    chk("s5_pred40", bus.pred_taken_f, 1'b1);
    chk("s5_tgt40", bus.pred_target_f, 32'h80);
    set_ex(1'b1, 2'b11, 32'h80, 1'b1, 32'hC0, 1'b0, 32'h0);
    #1;
    chk("s5_rbw_pred", bus.pred_taken_f, 1'b1);
    chk("s5_rbw_tgt", bus.pred_target_f, 32'h80);
    chk("s5_rpc", bus.redirect_pc, 32'hC0);
    tick();
    idle();
    #1;
    chk("s5_alias_miss", bus.pred_taken_f, 1'b0);
    bus.pc_f = 32'h80;
    #1;
    chk("s5_pred80", bus.pred_taken_f, 1'b1);
    chk("s5_tgt80", bus.pred_target_f, 32'hC0);
    set_ex(1'b1, 2'b11, 32'h80, 1'b0, 32'h0, 1'b1, 32'hC0);
    #1;
    chk("nt_rpc", bus.redirect_pc, 32'h84);
    tick();
    idle();
    #1;
    chk("nt_pred", bus.pred_taken_f, 1'b1);
    chk("nt_tgt", bus.pred_target_f, 32'hC0);
    chk("nt_br", bus.stat_branches, 16'd10);
    chk("nt_mp", bus.stat_mispredicts, 16'd7);
    set_ex(1'b1, 2'b00, 32'h80, 1'b1, 32'h300, 1'b0, 32'h0);
    #1;
    chk("none_redir", bus.redirect, 1'b0);
    tick();
    set_ex(1'b0, 2'b11, 32'h80, 1'b1, 32'h300, 1'b0, 32'h0);
    #1;
    chk("bubble_redir", bus.redirect, 1'b0);
    tick();
    idle();
    #1;
    chk("none_br", bus.stat_branches, 16'd10);
    chk("none_mp", bus.stat_mispredicts, 16'd7);
    chk("none_tgt", bus.pred_target_f, 32'hC0);
    set_ex(1'b1, 2'b11, 32'h44, 1'b0, 32'h0, 1'b1, 32'h48);
    repeat (65530) tick();
    chk("sat_br", bus.stat_branches, 16'hFFFF);
    chk("sat_mp", bus.stat_mispredicts, 16'hFFFF);
    chk("sat_redir", bus.redirect, 1'b1);
    tick();
    chk("sat_mp2", bus.stat_mispredicts, 16'hFFFF);
    #2 rst = 1'b0;
    #1;
    chk("mrst_redir", bus.redirect, 1'b0);
    chk("mrst_br", bus.stat_branches, 16'h0);
    chk("mrst_mp", bus.stat_mispredicts, 16'h0);
    chk("mrst_pred", bus.pred_taken_f, 1'b0);
    tick();
    rst = 1'b1;
    idle();
    #1;
    chk("post_pred", bus.pred_taken_f, 1'b0);
    chk("post_tgt", bus.pred_target_f, 32'h0);
    set_ex(1'b1, 2'b11, 32'h80, 1'b1, 32'hC0, 1'b0, 32'h0);
    tick();
    idle();
    #1;
    chk("post_train_pred", bus.pred_taken_f, 1'b1);
    chk("post_train_tgt", bus.pred_target_f, 32'hC0);
    chk("post_br", bus.stat_branches, 16'd1);
    chk("post_mp", bus.stat_mispredicts, 16'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
